// File: rtl/out_unit_nport_pkg.sv
// Shared definitions for the router output unit: STOP select encoding,
// default parameters and the select/count width helpers.
package out_unit_nport_pkg;

  localparam int DEF_NUM_PORTS  = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // port_sw_id value meaning "no input routed this cycle"
  localparam int SW_STOP = 0;

  function automatic int sel_width(input int num_ports);
    return $clog2(num_ports + 1);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/out_unit_nport_fifo.sv
// out_fifo: synchronous FIFO buffering flits between the crossbar and the
// output register. full/empty/count come straight from the occupancy register.
module out_fifo
  import out_unit_nport_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/out_unit_nport.sv
// Router output unit: N-input crossbar column, flit FIFO and registered output.
// Optional flit counter output enabled by defining OUT_UNIT_FLIT_CNT_EN.
module out_unit_nport
  import out_unit_nport_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                full,
  input  logic [sel_width(NUM_PORTS)-1:0]     port_sw_id,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     data_in,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_valid,
  output logic                                buf_full,
  output logic [cnt_width(FIFO_DEPTH)-1:0]    buf_count,
`ifdef OUT_UNIT_FLIT_CNT_EN
  output logic [31:0]                         flit_cnt,
`endif
  output logic                                ovf_err
);

  localparam int SEL_W = sel_width(NUM_PORTS);

  logic [DATA_WIDTH-1:0] xbar_flit;
  logic [DATA_WIDTH-1:0] head_flit;
  logic                  sel_ok;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;

  // selects above NUM_PORTS behave exactly like STOP
  assign sel_ok = (port_sw_id != SEL_W'(SW_STOP)) && (port_sw_id <= SEL_W'(NUM_PORTS));

  always_comb begin
    xbar_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sw_id == SEL_W'(i + 1)) xbar_flit = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign push = sel_ok && !buf_full;
  assign pop  = !full && !fifo_empty;

  out_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (xbar_flit),
    .rdata (head_flit),
    .count (buf_count),
    .full  (buf_full),
    .empty (fifo_empty)
  );

  // while downstream is full the output register simply holds its flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (!full) begin
      data_out   <= fifo_empty ? '0 : head_flit;
      data_valid <= !fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (sel_ok && buf_full) begin
      ovf_err <= 1'b1;
    end
  end

`ifdef OUT_UNIT_FLIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt <= '0;
    end else if (pop) begin
      flit_cnt <= flit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_out_unit_nport.sv
// Scoreboard bench for out_unit_nport: a queue model predicts popped flits,
// an independent monitor compares them as the DUT presents them.
module tb_out_unit_nport;
  import out_unit_nport_pkg::*;

  localparam int NP = DEF_NUM_PORTS;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int FD = DEF_FIFO_DEPTH;
  localparam int SW = $clog2(NP + 1);
  localparam int CW = $clog2(FD + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            full = 1'b0;
  logic [SW-1:0]   port_sw_id = '0;
  logic [NP*DW-1:0] data_in = '0;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic            buf_full;
  logic [CW-1:0]   buf_count;
  logic            ovf_err;
`ifdef OUT_UNIT_FLIT_CNT_EN
  logic [31:0]     flit_cnt;
`endif

  out_unit_nport dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .full       (full),
    .port_sw_id (port_sw_id),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .buf_full   (buf_full),
    .buf_count  (buf_count),
`ifdef OUT_UNIT_FLIT_CNT_EN
    .flit_cnt   (flit_cnt),
`endif
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_m[$];
  logic [DW-1:0] exp_q[$];
  bit            ovf_m = 1'b0;
  int unsigned   pops_m = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // one clock: drive inputs now, apply the buffering rules at the edge,
  // check occupancy/flags on the following falling edge
  task automatic cycle(input bit f, input int sel, input logic [DW-1:0] flit);
    int pre;
    for (int i = 0; i < NP; i++) data_in[i*DW +: DW] = $urandom;
    if (sel >= 1 && sel <= NP) data_in[(sel-1)*DW +: DW] = flit;
    full       = f;
    port_sw_id = SW'(sel);
    @(posedge clk);
    pre = fifo_m.size();
    if (!f && pre > 0) begin
      exp_q.push_back(fifo_m.pop_front());
      pops_m++;
    end
    if (sel >= 1 && sel <= NP) begin
      if (pre < FD) fifo_m.push_back(flit);
      else ovf_m = 1'b1;
    end
    @(negedge clk);
    chk("buf_count", 64'(buf_count), 64'(fifo_m.size()));
    chk("buf_full", 64'(buf_full), 64'(fifo_m.size() == FD));
    chk("ovf_err", 64'(ovf_err), 64'(ovf_m));
`ifdef OUT_UNIT_FLIT_CNT_EN
    chk("flit_cnt", 64'(flit_cnt), 64'(pops_m));
`endif
  endtask

  logic          full_cap;
  logic [DW-1:0] last_out = '0;
  logic          last_valid = 1'b0;

  always @(posedge clk) full_cap <= full;

  always @(negedge clk) begin
    if (rst_n) begin
      if (full_cap) begin
        chk("hold_data", 64'(data_out), 64'(last_out));
        chk("hold_valid", 64'(data_valid), 64'(last_valid));
      end else if (data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit actual=%0h required=none", data_out);
        end else begin
          chk("flit_order", 64'(data_out), 64'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_zero", 64'(data_out), 64'd0);
        chk("no_gap", 64'(exp_q.size()), 64'd0);
      end
      last_out   = data_out;
      last_valid = data_valid;
    end
  end

  task automatic do_reset();
    full       = 1'b0;
    port_sw_id = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_count", 64'(buf_count), 64'd0);
    chk("rst_buf_full", 64'(buf_full), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    fifo_m.delete();
    exp_q.delete();
    ovf_m      = 1'b0;
    pops_m     = 0;
    last_out   = '0;
    last_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < FD + 4 && fifo_m.size() > 0; i++) cycle(1'b0, 0, '0);
    cycle(1'b0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // minimum latency: push on edge 0, visible after edge 1, gone after edge 2
    cycle(1'b0, 3, 32'hA5A5A5A5);
    chk("lat_valid_e0", 64'(data_valid), 64'd0);
    cycle(1'b0, 0, '0);
    chk("lat_data_e1", 64'(data_out), 64'hA5A5A5A5);
    chk("lat_valid_e1", 64'(data_valid), 64'd1);
    cycle(1'b0, 0, '0);
    chk("lat_valid_e2", 64'(data_valid), 64'd0);

    // out-of-range selects are STOP
    cycle(1'b0, 7, $urandom);
    cycle(1'b0, 6, $urandom);
    cycle(1'b1, 7, $urandom);
    cycle(1'b0, 0, '0);

    // backpressure fill from ports 0..3, then release
    for (int p = 1; p <= 4; p++) cycle(1'b1, p, $urandom);
    chk("bp_buf_full", 64'(buf_full), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, '0);
    chk("bp_empty", 64'(buf_count), 64'd0);
    drain();

    // overflow while full, then push-on-full coinciding with a pop
    for (int p = 1; p <= 4; p++) cycle(1'b1, p, $urandom);
    cycle(1'b1, 1, 32'hDEADBEEF);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_count", 64'(buf_count), 64'd4);
    cycle(1'b0, 2, 32'h0BADF00D);
    drain();

    // reset with three flits buffered and data held
    for (int p = 1; p <= 3; p++) cycle(1'b1, p, $urandom);
    do_reset();
    cycle(1'b0, 0, '0);
    chk("post_rst_count", 64'(buf_count), 64'd0);

    // streaming: one push per cycle with no downstream stall
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, $urandom_range(1, NP), $urandom);
      chk("stream_count", 64'(buf_count), 64'd1);
    end
    drain();

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 3), $urandom_range(0, (1 << SW) - 1), $urandom);
    drain();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
